// File: rtl/fast_field_grouper.sv
// FAST stop-bit field grouper: scans one byte lane per cycle, packs 7-bit payloads into
// right-aligned fields and queues them in a fall-through FIFO. Define FAST_GROUP_STATS_EN for stat counters.
module fast_field_grouper #(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int MAX_FIELD_BYTES     = 8,
  parameter int FIFO_DEPTH_BITS     = 4,
  parameter int LEN_WIDTH           = $clog2(MAX_FIELD_BYTES + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [7*MAX_FIELD_BYTES-1:0]     m_field_data,
  output logic [LEN_WIDTH-1:0]             m_field_len,
  output logic [1:0]                       m_field_err,
  output logic                             m_field_last,
  output logic                             m_field_valid,
  input  logic                             m_field_ready
`ifdef FAST_GROUP_STATS_EN
  ,
  output logic [31:0]                      stat_fields,
  output logic [31:0]                      stat_errors
`endif
);

  localparam int LANES = C_S_AXIS_DATA_WIDTH / 8;
  localparam int PW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW    = 7 * MAX_FIELD_BYTES;
  localparam int EW    = AW + LEN_WIDTH + 3;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SCAN    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]                     state_q, state_d, p_state;
  logic                           held_q, en_q;
  logic [PW-1:0]                  ptr_q;
  logic [C_S_AXIS_DATA_WIDTH-1:0] data_q;
  logic [LANES-1:0]               keep_q;
  logic                           last_q;
  logic [AW-1:0]                  acc_q, acc_d, p_acc, nacc;
  logic [LEN_WIDTH-1:0]           cnt_q, cnt_d, p_cnt, ncnt;

  logic [7:0]    lane_byte;
  logic          lane_kv, last_lane, later_kv, final_byte;
  logic          wr_req, wr_en, stall, accept, pop, full, empty;
  logic [EW-1:0] wr_entry, head;

  logic [FIFO_DEPTH_BITS:0] wp_q, rp_q;
  logic [EW-1:0]            mem_q [DEPTH];

  assign lane_byte  = data_q[{ptr_q, 3'b000} +: 8];
  assign lane_kv    = keep_q[ptr_q];
  assign last_lane  = (ptr_q == PW'(LANES - 1));
  assign later_kv   = ((keep_q >> ptr_q) >> 1) != '0;
  assign final_byte = last_q && lane_kv && !later_kv;
  assign nacc       = (acc_q << 7) | AW'(lane_byte[6:0]);
  assign ncnt       = cnt_q + 1'b1;

  // Work the held lane would do if the FIFO accepts its write this cycle.
  always_comb begin
    p_state  = state_q;
    p_acc    = acc_q;
    p_cnt    = cnt_q;
    wr_req   = 1'b0;
    wr_entry = '0;
    if (held_q) begin
      if (state_q == S_DISCARD) begin
        if (lane_kv && lane_byte[7]) p_state = S_SCAN;
      end else if (lane_kv) begin
        p_acc = '0;
        p_cnt = '0;
        if (lane_byte[7]) begin
          wr_req   = 1'b1;
          wr_entry = {nacc, ncnt, 2'b00, final_byte};
        end else if (ncnt == LEN_WIDTH'(MAX_FIELD_BYTES)) begin
          wr_req   = 1'b1;
          wr_entry = {nacc, ncnt, 2'b01, 1'b0};
          p_state  = S_DISCARD;
        end else if (final_byte) begin
          wr_req   = 1'b1;
          wr_entry = {nacc, ncnt, 2'b10, 1'b1};
        end else begin
          p_acc = nacc;
          p_cnt = ncnt;
        end
      end else if (last_lane && last_q && keep_q == '0 && cnt_q != '0) begin
        wr_req   = 1'b1;
        wr_entry = {acc_q, cnt_q, 2'b10, 1'b1};
        p_acc    = '0;
        p_cnt    = '0;
      end
    end
  end

  assign empty         = (wp_q == rp_q);
  assign full          = (wp_q[FIFO_DEPTH_BITS] != rp_q[FIFO_DEPTH_BITS]) &&
                         (wp_q[FIFO_DEPTH_BITS-1:0] == rp_q[FIFO_DEPTH_BITS-1:0]);
  assign pop           = !empty && m_field_ready;
  assign stall         = wr_req && full && !pop;
  assign wr_en         = wr_req && !stall;
  assign s_axis_tready = en_q && (!held_q || (last_lane && !stall));
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Discard mode survives a non-tlast beat boundary; a tlast boundary always returns to idle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (held_q && !stall) begin
      state_d = p_state;
      acc_d   = p_acc;
      cnt_d   = p_cnt;
      if (last_lane && (p_state != S_DISCARD || last_q))
        state_d = accept ? S_SCAN : S_IDLE;
    end else if (!held_q && accept && state_q == S_IDLE) begin
      state_d = S_SCAN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      held_q  <= 1'b0;
      en_q    <= 1'b0;
      ptr_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      en_q    <= 1'b1;
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        data_q <= s_axis_tdata;
        keep_q <= s_axis_tkeep;
        last_q <= s_axis_tlast;
        held_q <= 1'b1;
      end else if (held_q && last_lane && !stall) begin
        held_q <= 1'b0;
      end
      if (held_q && !stall) ptr_q <= last_lane ? '0 : ptr_q + 1'b1;
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (pop)   rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q[FIFO_DEPTH_BITS-1:0]] <= wr_entry;
  end

  assign head          = mem_q[rp_q[FIFO_DEPTH_BITS-1:0]];
  assign m_field_valid = !empty;
  assign {m_field_data, m_field_len, m_field_err, m_field_last} = empty ? '0 : head;

`ifdef FAST_GROUP_STATS_EN
  logic [31:0] sf_q, se_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sf_q <= '0;
      se_q <= '0;
    end else if (wr_en) begin
      if (sf_q != '1) sf_q <= sf_q + 1'b1;
      if (wr_entry[2:1] != 2'b00 && se_q != '1) se_q <= se_q + 1'b1;
    end
  end

  assign stat_fields = sf_q;
  assign stat_errors = se_q;
`endif

endmodule

// File: tb/tb_fast_field_grouper.sv
// Bench for fast_field_grouper: byte-list reference model with a per-cycle compare process,
// directed literal cases, back-pressure and randomized beats.
module tb_fast_field_grouper;

  typedef struct {
    logic [55:0] d;
    int          len;
    int          err;
    bit          last;
  } fld_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [55:0] m_field_data;
  logic [3:0]  m_field_len;
  logic [1:0]  m_field_err;
  logic        m_field_last;
  logic        m_field_valid;
  logic        m_field_ready = 1'b0;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   rst_cnt = 0;
  int   ready_mode = 1;
  fld_t expq[$];
  fld_t logq[$];
  logic [55:0] m_acc = '0;
  int          m_cnt = 0;
  bit          m_disc = 1'b0;

  fast_field_grouper #(
    .C_S_AXIS_DATA_WIDTH(64),
    .MAX_FIELD_BYTES(8),
    .FIFO_DEPTH_BITS(4),
    .LEN_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_field_data(m_field_data),
    .m_field_len(m_field_len),
    .m_field_err(m_field_err),
    .m_field_last(m_field_last),
    .m_field_valid(m_field_valid),
    .m_field_ready(m_field_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge reset) rst_cnt++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_field_ready = 1'b0;
      1:       m_field_ready = 1'b1;
      default: m_field_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void mpush(input logic [55:0] d, input int len, input int err, input bit last);
    fld_t f;
    f.d = d; f.len = len; f.err = err; f.last = last;
    expq.push_back(f);
  endfunction

  // Model: flatten the beat to its valid bytes, then apply the grouping rules byte by byte.
  function automatic void model_beat(input logic [63:0] d, input logic [7:0] k, input bit l);
    logic [7:0] bq[$];
    for (int i = 0; i < 8; i++) if (k[i]) bq.push_back(d[i*8 +: 8]);
    for (int i = 0; i < bq.size(); i++) begin
      logic [7:0] b;
      bit fin;
      b = bq[i];
      fin = l && (i == bq.size() - 1);
      if (m_disc) begin
        if (b[7]) m_disc = 1'b0;
      end else begin
        m_acc = (m_acc << 7) | 56'(b[6:0]);
        m_cnt++;
        if (b[7]) begin
          mpush(m_acc, m_cnt, 0, fin); m_acc = '0; m_cnt = 0;
        end else if (m_cnt == 8) begin
          mpush(m_acc, 8, 1, 1'b0); m_acc = '0; m_cnt = 0; m_disc = 1'b1;
        end else if (fin) begin
          mpush(m_acc, m_cnt, 2, 1'b1); m_acc = '0; m_cnt = 0;
        end
      end
    end
    if (l) begin
      if (m_cnt > 0) begin
        mpush(m_acc, m_cnt, 2, 1'b1); m_acc = '0; m_cnt = 0;
      end
      m_disc = 1'b0;
    end
  endfunction

  // Per-cycle compare: every popped head against the model, and head stability under back-pressure.
  logic [62:0] prev_o;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  int          prev_rc = 0;
  always @(negedge clk) begin
    logic [62:0] cur;
    fld_t e, a;
    cur = {m_field_data, m_field_len, m_field_err, m_field_last};
    if (!reset && rst_cnt == prev_rc && prev_v && !prev_r)
      chk("hold", {1'b0, m_field_valid, cur}, {1'b0, 1'b1, prev_o});
    if (!reset && m_field_valid && m_field_ready) begin
      a.d = m_field_data; a.len = int'(m_field_len); a.err = int'(m_field_err); a.last = m_field_last;
      logq.push_back(a);
      if (expq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL extra_field: got data %h len %0d, expected no field", m_field_data, m_field_len);
      end else begin
        e = expq.pop_front();
        chk("fld_data", 64'(m_field_data), 64'(e.d));
        chk("fld_len", 64'(m_field_len), 64'(e.len));
        chk("fld_err", 64'(m_field_err), 64'(e.err));
        chk("fld_last", 64'(m_field_last), 64'(e.last));
      end
    end
    prev_v = m_field_valid; prev_r = m_field_ready; prev_o = cur; prev_rc = rst_cnt;
  end

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit l);
    int w = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && w < 500) begin
      @(negedge clk); #1; w++;
    end
    if (!s_axis_tready) begin
      chk("beat_accept_timeout", 64'(s_axis_tready), 64'd1);
    end else begin
      hs_cyc = cyc;
      model_beat(d, k, l);
    end
    @(posedge clk);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((expq.size() != 0 || m_field_valid) && w < 3000) begin
      @(negedge clk); w++;
    end
    repeat (12) @(negedge clk);
    chk("drain_model_empty", 64'(expq.size()), 64'd0);
    chk("drain_valid_low", 64'(m_field_valid), 64'd0);
  endtask

  initial begin
    int t_a;
    reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    ready_mode = 1;
    #23;
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_valid", 64'(m_field_valid), 64'd0);
    chk("rst_data", 64'(m_field_data), 64'd0);
    chk("rst_len", 64'(m_field_len), 64'd0);
    chk("rst_err", 64'(m_field_err), 64'd0);
    chk("rst_last", 64'(m_field_last), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    chk("tready_after_reset", 64'(s_axis_tready), 64'd1);
    @(negedge clk);

    // Two-byte field closing a tlast beat: visible two cycles after the handshake.
    send_beat(64'h8201, 8'h03, 1'b1);
    @(negedge clk);
    chk("t1_valid_early", 64'(m_field_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid", 64'(m_field_valid), 64'd1);
    chk("t1_data", 64'(m_field_data), 64'h82);
    chk("t1_len", 64'(m_field_len), 64'd2);
    chk("t1_err", 64'(m_field_err), 64'd0);
    chk("t1_last", 64'(m_field_last), 64'd1);
    drain();

    // Eight one-byte fields on consecutive cycles, next beat taken in the 8th scan cycle.
    send_beat(64'h8887868584838281, 8'hFF, 1'b0);
    t_a = hs_cyc;
    fork
      send_beat(64'h81, 8'h01, 1'b1);
      begin
        for (int i = 1; i <= 8; i++) begin
          @(negedge clk);
          chk("t2_seq_valid", 64'(m_field_valid), 64'd1);
          chk("t2_seq_data", 64'(m_field_data), 64'(i));
        end
      end
    join
    chk("t2_back_to_back", 64'(hs_cyc - t_a), 64'd8);
    drain();

    // Overlong field, discard through the next stop byte, then resume.
    logq.delete();
    send_beat(64'h0101010101010101, 8'hFF, 1'b0);
    send_beat(64'h838501, 8'h07, 1'b0);
    drain();
    chk("t3_count", 64'(logq.size()), 64'd2);
    if (logq.size() == 2) begin
      chk("t3_ovl_data", 64'(logq[0].d), 64'h2040810204081);
      chk("t3_ovl_len", 64'(logq[0].len), 64'd8);
      chk("t3_ovl_err", 64'(logq[0].err), 64'd1);
      chk("t3_ovl_last", 64'(logq[0].last), 64'd0);
      chk("t3_next_data", 64'(logq[1].d), 64'h3);
      chk("t3_next_len", 64'(logq[1].len), 64'd1);
      chk("t3_next_err", 64'(logq[1].err), 64'd0);
    end

    // Truncated by tlast.
    logq.delete();
    send_beat(64'h0605, 8'h03, 1'b1);
    drain();
    chk("t4_count", 64'(logq.size()), 64'd1);
    if (logq.size() == 1) begin
      chk("t4_data", 64'(logq[0].d), 64'h286);
      chk("t4_len", 64'(logq[0].len), 64'd2);
      chk("t4_err", 64'(logq[0].err), 64'd2);
      chk("t4_last", 64'(logq[0].last), 64'd1);
    end

    // FIFO full: input stalls, nothing lost once the consumer resumes.
    ready_mode = 0;
    @(negedge clk); @(negedge clk);
    logq.delete();
    fork
      begin
        send_beat(64'h8887868584838281, 8'hFF, 1'b0);
        send_beat(64'h908F8E8D8C8B8A89, 8'hFF, 1'b0);
        send_beat(64'h939291, 8'h07, 1'b1);
      end
      begin
        repeat (40) @(negedge clk);
        #1;
        chk("t5_stall_tready", 64'(s_axis_tready), 64'd0);
        chk("t5_full_valid", 64'(m_field_valid), 64'd1);
        ready_mode = 1;
      end
    join
    drain();
    chk("t5_count", 64'(logq.size()), 64'd19);
    for (int i = 0; i < logq.size(); i++) chk("t5_order", 64'(logq[i].d), 64'(i + 1));

    // Asynchronous reset with a queued field and a partial field pending.
    ready_mode = 0;
    @(negedge clk); @(negedge clk);
    send_beat(64'h81, 8'h01, 1'b0);
    send_beat(64'h01, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_pre_valid", 64'(m_field_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(m_field_valid), 64'd0);
    chk("t6_rst_data", 64'(m_field_data), 64'd0);
    chk("t6_rst_len", 64'(m_field_len), 64'd0);
    chk("t6_rst_tready", 64'(s_axis_tready), 64'd0);
    expq.delete(); m_acc = '0; m_cnt = 0; m_disc = 1'b0;
    @(negedge clk); reset = 1'b0; ready_mode = 1;
    @(negedge clk); @(negedge clk);
    logq.delete();
    send_beat(64'h81, 8'h01, 1'b1);
    drain();
    chk("t6_count", 64'(logq.size()), 64'd1);
    if (logq.size() == 1) begin
      chk("t6_data", 64'(logq[0].d), 64'h1);
      chk("t6_len", 64'(logq[0].len), 64'd1);
      chk("t6_err", 64'(logq[0].err), 64'd0);
    end

    // Randomized beats with random consumer back-pressure.
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      logic [63:0] d;
      logic [7:0]  k;
      bit          l;
      for (int j = 0; j < 8; j++) d[j*8 +: 8] = {($urandom_range(0, 9) < 3), 7'($urandom)};
      k = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      l = ($urandom_range(0, 3) == 0);
      send_beat(d, k, l);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    ready_mode = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
